// File: rtl/bias_apply_pkg.sv
// bias_apply_pkg: shared widths, layer sizes and state encoding for the bias stage.
package bias_apply_pkg;
    localparam int COEFF_WIDTH   = 16;
    localparam int ACC_WIDTH     = 32;
    localparam int OUT_WIDTH     = 16;
    localparam int N_CH_DEF      = 16;
    localparam int FRAME_PIX_DEF = 64;
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/bias_apply_sat_add.sv
// bias_apply_sat_add: sign-extends accumulator and bias, adds at ACC_W+1 bits, saturates to OUT_W.
module bias_apply_sat_add
    import bias_apply_pkg::*;
#(
    parameter int ACC_W   = ACC_WIDTH,
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int OUT_W   = OUT_WIDTH
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [COEFF_W-1:0] bias_i,
    output logic [OUT_W-1:0]   sum_o
);
    localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SMIN = -SMAX - 1;
    logic signed [ACC_W:0] sum;
    // One extra bit means the raw sum can never wrap before the clamp.
    assign sum   = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-COEFF_W){bias_i[COEFF_W-1]}}, bias_i};
    assign sum_o = sum > SMAX ? {1'b0, {(OUT_W-1){1'b1}}} :
                   sum < SMIN ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];
endmodule

// File: rtl/bias_apply.sv
// bias_apply: loads N_CH biases per frame, then adds them to a channel-interleaved
// accumulator stream and writes saturated results to an ap_fifo.
module bias_apply
    import bias_apply_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int FRAME_PIX = FRAME_PIX_DEF,
    parameter int COEFF_W   = COEFF_WIDTH,
    parameter int ACC_W     = ACC_WIDTH,
    parameter int OUT_W     = OUT_WIDTH
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   input_V_dout,
    input  logic               input_V_empty_n,
    output logic               input_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);
    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(FRAME_PIX);
    state_e             state_q, state_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [PW-1:0]      pix_q, pix_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_reg_q, out_reg_d, sum;
    logic [COEFF_W-1:0] bank_q [N_CH];
    logic               bias_pop, accept, ch_last, pix_last;

    bias_apply_sat_add #(.ACC_W(ACC_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W)) u_sat (
        .acc_i  (input_V_dout),
        .bias_i (bank_q[ch_q]),
        .sum_o  (sum)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        out_valid_d = out_valid_q;
        out_reg_d   = out_reg_q;
        ch_last     = ch_q == CW'(N_CH - 1);
        pix_last    = pix_q == PW'(FRAME_PIX - 1);
        bias_pop    = state_q == LOAD && bias_V_empty_n;
        accept      = state_q == RUN && input_V_empty_n && (!out_valid_q || output_V_full_n);
        if (bias_pop) begin
            ch_d    = ch_last ? '0 : ch_q + 1'b1;
            state_d = ch_last ? RUN : LOAD;
        end
        if (out_valid_q && output_V_full_n)
            out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_reg_d   = sum;
            ch_d        = ch_last ? '0 : ch_q + 1'b1;
            if (ch_last) begin
                pix_d   = pix_last ? '0 : pix_q + 1'b1;
                state_d = pix_last ? LOAD : RUN;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= LOAD;
            ch_q        <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            out_reg_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            out_valid_q <= out_valid_d;
            out_reg_q   <= out_reg_d;
        end
    end

    // Bank keeps its contents through reset; every frame rewrites it before use.
    always_ff @(posedge ap_clk) begin
        if (bias_pop)
            bank_q[ch_q] <= bias_V_dout;
    end

    // LOAD is the reset state, so the bias pop must be masked while reset is held.
    assign bias_V_read    = bias_pop & ap_rst_n;
    assign input_V_read   = accept;
    assign output_V_write = out_valid_q & output_V_full_n;
    assign output_V_din   = out_reg_q;
endmodule

// File: doc/bias_apply.md
Name: bias_apply

Overview:
- Consumer end of a bias stream such as the one produced by the bias_s_<n> + rom streamers; it sits on the read side of that ap_fifo.
- Pops N_CH bias coefficients into a local register bank, then adds them to a channel-interleaved accumulator stream from the convolution.
- Emits saturated results on an ap_fifo write interface toward the activation/next layer.
- Reloads the bias bank at the start of every frame.

Parameters:
- N_CH, 16, output channels per pixel; bias words loaded per frame (`kern_s_k_<n>`).
- FRAME_PIX, 64, pixels per frame; RUN consumes FRAME_PIX*N_CH accumulators.
- COEFF_W, 16, bias width (`coeff_width`), signed two's complement.
- ACC_W, 32, accumulator input width, signed.
- OUT_W, 16, output width, signed.

Ports:
- ap_clk  in  1  single clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- bias_V_dout  in  COEFF_W  bias FIFO head data; valid while bias_V_empty_n=1.
- bias_V_empty_n  in  1  bias FIFO not empty.
- bias_V_read  out  1  pops bias FIFO head this cycle.
- input_V_dout  in  ACC_W  accumulator FIFO head data.
- input_V_empty_n  in  1  accumulator FIFO not empty.
- input_V_read  out  1  pops accumulator FIFO head.
- output_V_din  out  OUT_W  result data.
- output_V_full_n  in  1  output FIFO not full.
- output_V_write  out  1  writes output_V_din this cycle.

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD; ch_cnt=0; pix_cnt=0; out_valid=0; out_reg=0.
  - bias bank is not cleared.
  - All outputs are 0 during reset.
- FIFO rules:
  - A pop occurs on a rising edge with read=1; read is asserted only when empty_n=1.
  - A write occurs with write=1; write is asserted only when full_n=1.
- State LOAD:
  - bias_V_read = bias_V_empty_n.
  - Each pop stores bias_V_dout into bank[ch_cnt] and increments ch_cnt.
  - On the pop with ch_cnt=N_CH-1: ch_cnt<=0, state<=RUN.
  - input_V_read=0 throughout LOAD.
- State RUN:
  - accept = input_V_empty_n & (!out_valid | output_V_full_n); input_V_read = accept.
  - On accept: out_reg <= sat_OUT_W(sext(input_V_dout) + sext(bank[ch_cnt])), computed at ACC_W+1 bits; out_valid<=1; ch_cnt increments.
  - On ch_cnt wrap (N_CH-1 -> 0), pix_cnt increments.
  - On the accept with ch_cnt=N_CH-1 and pix_cnt=FRAME_PIX-1: counters <=0, state<=LOAD.
  - bias_V_read=0 throughout RUN.
- Output register:
  - output_V_write = out_valid & output_V_full_n; output_V_din = out_reg.
  - If a write occurs with no same-cycle accept: out_valid<=0.
  - If a write and an accept occur in the same cycle: out_valid stays 1 and out_reg takes the new value.
  - Full throughput is 1 result/cycle.
- Latency: 1 cycle from accumulator pop to output_V_write (when full_n=1).
- Saturation: sum > 2^(OUT_W-1)-1 gives 0x7FFF; sum < -2^(OUT_W-1) gives 0x8000 (OUT_W=16).
- Frame boundary: the last result may still be pending in out_reg while LOAD begins. LOAD proceeds regardless; out_reg drains independently.
- Backpressure: while full_n=0 and out_valid=1, input_V_read=0 and out_reg holds.
- Empty inputs: no pop and counters hold; there is no timeout.
- Reset mid-frame: counters and state are discarded and the next frame starts in LOAD. Upstream FIFOs must also be reset.

Decomposition:
- Shared package/header: COEFF_W/ACC_W/OUT_W defaults from `coeff_width` and the layer sizes; a state encoding typedef (LOAD=0, RUN=1).
- One sub-module, sat_add: combinational sign-extend, add and saturate (ACC_W + COEFF_W -> OUT_W).

Test Plan:
- Load: N_CH=4, biases {1,-2,3,-4}, then accumulators {10,10,10,10} -> outputs {11,8,13,6}. bias_V_read is high for exactly 4 cycles.
- Saturation: bias 0x7FFF with acc 0x00007FFF -> 0x7FFF; bias 0x8000 with acc 0xFFFF8000 -> 0x8000.
- Throughput: both FIFOs always non-empty and full_n=1. After the first pop, output_V_write stays high with one result per cycle for the whole frame.
- Backpressure: drop full_n for 5 cycles mid-frame -> input_V_read=0 and output_V_din is stable. On resume there is no loss or duplication and the sequence matches the golden model.
- Frame rollover: FRAME_PIX=2, N_CH=4. After 8 results, state returns to LOAD and the new biases {0,0,0,100} apply to frame 2. The last result of frame 1 still uses the old bias 3rd/4th entries.
- Async reset asserted mid-RUN (not on a clock edge) -> all outputs drop to 0 immediately. After release the block restarts in LOAD with ch_cnt=0.
